// File: rtl/feed_scheduler.sv
// feed_scheduler: counts down a feeding interval in one-second ticks, then drives the
// dispensing motor until the requested portions are confirmed by the portion sensor.
// If no portion arrives within the per-portion timeout, it latches a fault.
// Optional feature macro: FEED_SCHEDULER_MANUAL_EN. When it is defined, i_manual starts an
// immediate feed from COUNT. When it is undefined, i_manual is ignored.
module feed_scheduler #(
    parameter logic [31:0] CLOCK_FREQ        = 32'd50_000_000,
    parameter logic [16:0] INTERVAL_S        = 17'd28800,
    parameter logic [7:0]  PORTION_TIMEOUT_S = 8'd10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m_state,
    input  logic        i_manual,
    input  logic        sensor_on,
    input  logic [2:0]  porciones,
    output logic        o_m_on,
    output logic        o_busy,
    output logic        o_fault,
    output logic [1:0]  o_state,
    output logic [16:0] o_remaining_s,
    output logic [2:0]  o_portions_done
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNT    = 2'd1,
        DISPENSE = 2'd2,
        FAULT    = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] tick_cnt;
    logic        tick;
    logic [7:0]  timeout_cnt;
    logic [7:0]  timeout_next;
    logic [2:0]  target;
    logic [2:0]  done_next;
    logic        sensor_meta;
    logic        sensor_sync;
    logic        sensor_prev;
    logic        sensor_rise;
    logic        manual_req;

`ifdef FEED_SCHEDULER_MANUAL_EN
    assign manual_req = i_manual;
`else
    assign manual_req = 1'b0 & i_manual;
`endif

    assign tick         = (tick_cnt == CLOCK_FREQ - 32'd1);
    assign done_next    = o_portions_done + 3'd1;
    assign timeout_next = timeout_cnt + 8'd1;
    assign o_state      = state;

    // Synchronise the sensor, then register a single-cycle pulse on each rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sensor_meta <= 1'b0;
            sensor_sync <= 1'b0;
            sensor_prev <= 1'b0;
            sensor_rise <= 1'b0;
        end else begin
            sensor_meta <= sensor_on;
            sensor_sync <= sensor_meta;
            sensor_prev <= sensor_sync;
            sensor_rise <= sensor_sync & ~sensor_prev;
        end
    end

    // Scheduler FSM: runs the tick divider and countdown, dispenses portions and detects timeouts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            tick_cnt        <= '0;
            timeout_cnt     <= '0;
            target          <= '0;
            o_m_on          <= 1'b0;
            o_busy          <= 1'b0;
            o_fault         <= 1'b0;
            o_remaining_s   <= '0;
            o_portions_done <= '0;
        end else begin
            if (state == COUNT || state == DISPENSE)
                tick_cnt <= tick ? '0 : tick_cnt + 32'd1;
            else
                tick_cnt <= '0;

            case (state)
                IDLE: begin
                    if (m_state) begin
                        state         <= COUNT;
                        o_remaining_s <= INTERVAL_S;
                        tick_cnt      <= '0;
                    end
                end

                COUNT: begin
                    if (!m_state) begin
                        state         <= IDLE;
                        o_remaining_s <= '0;
                        tick_cnt      <= '0;
                    end else begin
                        if (tick && o_remaining_s != 17'd0)
                            o_remaining_s <= o_remaining_s - 17'd1;
                        if ((tick && o_remaining_s == 17'd1) || manual_req) begin
                            state           <= DISPENSE;
                            o_busy          <= 1'b1;
                            o_m_on          <= (porciones != 3'd0);
                            target          <= porciones;
                            o_portions_done <= '0;
                            timeout_cnt     <= '0;
                            tick_cnt        <= '0;
                        end
                    end
                end

                DISPENSE: begin
                    if (!m_state) begin
                        state         <= IDLE;
                        o_m_on        <= 1'b0;
                        o_busy        <= 1'b0;
                        o_remaining_s <= '0;
                        tick_cnt      <= '0;
                    end else if (target == 3'd0) begin
                        state         <= COUNT;
                        o_m_on        <= 1'b0;
                        o_busy        <= 1'b0;
                        o_remaining_s <= INTERVAL_S;
                        tick_cnt      <= '0;
                    end else if (sensor_rise) begin
                        o_portions_done <= done_next;
                        timeout_cnt     <= '0;
                        if (done_next == target) begin
                            state         <= COUNT;
                            o_m_on        <= 1'b0;
                            o_busy        <= 1'b0;
                            o_remaining_s <= INTERVAL_S;
                            tick_cnt      <= '0;
                        end
                    end else if (tick) begin
                        timeout_cnt <= timeout_next;
                        if (timeout_next == PORTION_TIMEOUT_S) begin
                            state    <= FAULT;
                            o_m_on   <= 1'b0;
                            o_busy   <= 1'b0;
                            o_fault  <= 1'b1;
                            tick_cnt <= '0;
                        end
                    end
                end

                FAULT: begin
                    if (!m_state) begin
                        state         <= IDLE;
                        o_fault       <= 1'b0;
                        o_remaining_s <= '0;
                        tick_cnt      <= '0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_feed_scheduler.sv
// tb_feed_scheduler: directed scenarios for feed_scheduler with a cycle-level reference model
// built from elapsed-time arithmetic. It also includes literal spot checks that pin the model.
module tb_feed_scheduler;

    localparam int CF    = 20;
    localparam int INT_S = 3;
    localparam int TO_S  = 2;
`ifdef FEED_SCHEDULER_MANUAL_EN
    localparam bit MANUAL_EN = 1'b1;
`else
    localparam bit MANUAL_EN = 1'b0;
`endif

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        m_state   = 1'b0;
    logic        i_manual  = 1'b0;
    logic        sensor_on = 1'b0;
    logic [2:0]  porciones = 3'd0;
    logic        o_m_on;
    logic        o_busy;
    logic        o_fault;
    logic [1:0]  o_state;
    logic [16:0] o_remaining_s;
    logic [2:0]  o_portions_done;

    int checks = 0;
    int errors = 0;

    // Reference model state: phase, edges since phase entry, edge of last counted portion.
    int mdl_state  = 0;
    int mdl_c      = 0;
    int mdl_last   = 0;
    int mdl_rem    = 0;
    int mdl_done   = 0;
    int mdl_target = 0;
    int mdl_motor  = 0;
    int mdl_edge   = 0;
    bit mdl_sprev  = 1'b0;
    bit mdl_counted;
    int mdl_due[$];

    feed_scheduler #(
        .CLOCK_FREQ(32'd20),
        .INTERVAL_S(17'd3),
        .PORTION_TIMEOUT_S(8'd2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .m_state(m_state),
        .i_manual(i_manual),
        .sensor_on(sensor_on),
        .porciones(porciones),
        .o_m_on(o_m_on),
        .o_busy(o_busy),
        .o_fault(o_fault),
        .o_state(o_state),
        .o_remaining_s(o_remaining_s),
        .o_portions_done(o_portions_done)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic run, input logic [2:0] portions);
        m_state   = run;
        porciones = portions;
    endtask

    task automatic sensor_pulse();
        sensor_on = 1'b1;
        repeat (2) @(negedge clk);
        sensor_on = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_state(input logic [1:0] st, input int limit, input string name);
        int n;
        n = 0;
        while (o_state !== st && n < limit) begin
            @(negedge clk);
            n++;
        end
        check_output(name, o_state, st);
    endtask

    // Reference model: a sensor rise seen at edge N is counted at edge N+3 if the model is dispensing.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mdl_state = 0; mdl_c = 0; mdl_last = 0; mdl_rem = 0;
                mdl_done = 0; mdl_target = 0; mdl_motor = 0; mdl_edge = 0;
                mdl_sprev = 1'b0;
                mdl_due.delete();
            end else begin
                mdl_edge++;
                mdl_counted = 1'b0;
                if (mdl_due.size() > 0 && mdl_due[0] == mdl_edge) begin
                    void'(mdl_due.pop_front());
                    mdl_counted = 1'b1;
                end
                if (sensor_on && !mdl_sprev) mdl_due.push_back(mdl_edge + 3);
                mdl_sprev = sensor_on;
                case (mdl_state)
                    0: if (m_state) begin
                        mdl_state = 1; mdl_rem = INT_S; mdl_c = 0;
                    end
                    1: if (!m_state) begin
                        mdl_state = 0; mdl_rem = 0;
                    end else begin
                        mdl_c++;
                        mdl_rem = INT_S - mdl_c / CF;
                        if (mdl_rem == 0 || (MANUAL_EN && i_manual)) begin
                            mdl_state = 2; mdl_target = int'(porciones); mdl_done = 0;
                            mdl_c = 0; mdl_last = 0; mdl_motor = (porciones != 3'd0) ? 1 : 0;
                        end
                    end
                    2: if (!m_state) begin
                        mdl_state = 0; mdl_rem = 0; mdl_motor = 0;
                    end else if (mdl_target == 0) begin
                        mdl_state = 1; mdl_rem = INT_S; mdl_c = 0; mdl_motor = 0;
                    end else begin
                        mdl_c++;
                        if (mdl_counted) begin
                            mdl_done++;
                            mdl_last = mdl_c;
                            if (mdl_done == mdl_target) begin
                                mdl_state = 1; mdl_rem = INT_S; mdl_c = 0; mdl_motor = 0;
                            end
                        end else if (mdl_c / CF - mdl_last / CF >= TO_S) begin
                            mdl_state = 3; mdl_motor = 0;
                        end
                    end
                    default: if (!m_state) begin
                        mdl_state = 0; mdl_rem = 0;
                    end
                endcase
            end
        end
    end

    // Every-cycle comparison of all outputs against the model, on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check_output("state", o_state, mdl_state);
                check_output("motor", o_m_on, mdl_motor);
                check_output("busy", o_busy, (mdl_state == 2) ? 1 : 0);
                check_output("fault", o_fault, (mdl_state == 3) ? 1 : 0);
                check_output("remaining", o_remaining_s, mdl_rem);
                check_output("portions", o_portions_done, mdl_done);
            end
        end
    end

    // Directed scenarios with literal expectations.
    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("reset_state", o_state, 0);
        check_output("reset_motor", o_m_on, 0);
        check_output("reset_remaining", o_remaining_s, 0);
        check_output("reset_portions", o_portions_done, 0);

        // Automatic feed of two portions.
        apply_stimulus(1'b1, 3'd2);
        @(negedge clk);
        check_output("count_load", o_remaining_s, 3);
        check_output("count_state", o_state, 1);
        repeat (20) @(negedge clk);
        check_output("rem_2", o_remaining_s, 2);
        repeat (20) @(negedge clk);
        check_output("rem_1", o_remaining_s, 1);
        repeat (20) @(negedge clk);
        check_output("rem_0", o_remaining_s, 0);
        check_output("expiry_state", o_state, 2);
        check_output("expiry_motor", o_m_on, 1);
        sensor_pulse();
        sensor_pulse();
        check_output("done_portions", o_portions_done, 2);
        check_output("done_motor", o_m_on, 0);
        check_output("done_state", o_state, 1);
        check_output("done_reload", o_remaining_s, 3);

        // Zero portions: one cycle in DISPENSE with the motor off.
        apply_stimulus(1'b1, 3'd0);
        wait_state(2'd2, 80, "zero_enter");
        check_output("zero_motor", o_m_on, 0);
        @(negedge clk);
        check_output("zero_return", o_state, 1);
        check_output("zero_reload", o_remaining_s, 3);

        // Jammed hopper: FAULT after two ticks.
        apply_stimulus(1'b1, 3'd3);
        wait_state(2'd2, 80, "jam_enter");
        check_output("jam_motor", o_m_on, 1);
        repeat (39) @(negedge clk);
        check_output("jam_pre_fault", o_state, 2);
        @(negedge clk);
        check_output("jam_fault_state", o_state, 3);
        check_output("jam_fault_flag", o_fault, 1);
        check_output("jam_fault_motor", o_m_on, 0);
        apply_stimulus(1'b0, 3'd3);
        @(negedge clk);
        check_output("fault_clear_state", o_state, 0);
        check_output("fault_clear_flag", o_fault, 0);

        // Sensor edge on the same edge as the second timeout tick.
        apply_stimulus(1'b1, 3'd2);
        wait_state(2'd1, 5, "race_count");
        wait_state(2'd2, 80, "race_enter");
        repeat (36) @(negedge clk);
        sensor_pulse();
        check_output("race_state", o_state, 2);
        check_output("race_portions", o_portions_done, 1);
        check_output("race_no_fault", o_fault, 0);
        sensor_pulse();
        check_output("race_complete", o_state, 1);
        check_output("race_done", o_portions_done, 2);

        // Manual request at two seconds remaining.
        begin
            int n;
            n = 0;
            while (o_remaining_s !== 17'd2 && n < 40) begin
                @(negedge clk);
                n++;
            end
            check_output("manual_wait", o_remaining_s, 2);
        end
        i_manual = 1'b1;
        @(negedge clk);
        i_manual = 1'b0;
        check_output("manual_state", o_state, MANUAL_EN ? 2 : 1);
        check_output("manual_motor", o_m_on, MANUAL_EN ? 1 : 0);
        check_output("manual_remaining", o_remaining_s, 2);
        apply_stimulus(1'b0, 3'd2);
        @(negedge clk);
        check_output("stop_state", o_state, 0);

        // Asynchronous reset in the middle of dispensing.
        apply_stimulus(1'b1, 3'd2);
        wait_state(2'd2, 100, "rst_enter");
        sensor_pulse();
        check_output("rst_pre_portions", o_portions_done, 1);
        check_output("rst_pre_motor", o_m_on, 1);
        #2 rst_n = 1'b0;
        #1;
        check_output("rst_motor", o_m_on, 0);
        check_output("rst_busy", o_busy, 0);
        check_output("rst_fault", o_fault, 0);
        check_output("rst_state", o_state, 0);
        check_output("rst_remaining", o_remaining_s, 0);
        check_output("rst_portions", o_portions_done, 0);
        apply_stimulus(1'b0, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_output("post_reset_state", o_state, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
